// File: rtl/ulpi_tx_packetizer.sv
// ulpi_tx_packetizer
//   Captures a PID plus up to MAX_BYTES payload bytes in one cycle and sends
//   them over the ULPI data bus as TXCMD, payload and an optional USB CRC16
//   (low byte first). The stp strobe ends the packet. The PHY paces each byte
//   with nxt. If the PHY takes the bus with dir, the packet is dropped.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   start         one-cycle load request (honoured only in IDLE with dir=0)
//   pid           USB PID, TXCMD byte = {4'b0100, pid}
//   len_in        payload byte count (0 = ZLP, clamped to MAX_BYTES)
//   data_in       payload, byte k at [8k+7:8k], byte 0 sent first
//   nxt, dir      ULPI PHY handshake inputs
//   data_out, stp ULPI link outputs (registered)
//   busy          high outside IDLE
//   done          one-cycle pulse with stp
//   aborted       one-cycle pulse when dir kills a packet
module ulpi_tx_packetizer #(
    parameter int MAX_BYTES = 64,
    parameter int CRC_EN    = 1,
    parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             pid,
    input  logic [LEN_W-1:0]       len_in,
    input  logic [MAX_BYTES*8-1:0] data_in,
    input  logic                   nxt,
    input  logic                   dir,
    output logic [7:0]             data_out,
    output logic                   stp,
    output logic                   busy,
    output logic                   done,
    output logic                   aborted
);

    typedef enum logic [2:0] {
        S_IDLE, S_TXCMD, S_DATA, S_CRC_LO, S_CRC_HI, S_STOP
    } state_t;

    state_t                 state_q;
    logic [MAX_BYTES*8-1:0] buf_q;
    logic [LEN_W-1:0]       len_q;
    logic [LEN_W-1:0]       idx_q;
    logic [15:0]            crc_q;
    logic [7:0]             data_out_q;
    logic                   stp_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   aborted_q;

    logic [LEN_W-1:0]       len_d;
    logic [LEN_W-1:0]       idx_d;
    logic [15:0]            crc_d;
    logic [MAX_BYTES*8-1:0] buf_d;

    // One byte of reflected CRC16 (poly 0xA001), LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = {1'b0, r[15:1]} ^ 16'hA001;
            else             r = {1'b0, r[15:1]};
        end
        return r;
    endfunction

    // The payload buffer shifts down one byte per accepted byte, so the byte
    // on the bus is always buf_q[7:0] and no wide index mux is needed.
    always_comb begin
        len_d = (len_in > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len_in;
        idx_d = idx_q + LEN_W'(1);
        crc_d = crc16_byte(crc_q, buf_q[7:0]);
        buf_d = buf_q >> 8;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            crc_q      <= '0;
            data_out_q <= 8'h00;
            stp_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            stp_q     <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    data_out_q <= 8'h00;
                    busy_q     <= 1'b0;
                    if (start && !dir) begin
                        buf_q      <= data_in;
                        len_q      <= len_d;
                        idx_q      <= '0;
                        crc_q      <= 16'hFFFF;
                        data_out_q <= {4'b0100, pid};
                        busy_q     <= 1'b1;
                        state_q    <= S_TXCMD;
                    end
                end
                S_STOP: begin
                    // dir is ignored here: stp has already been driven.
                    data_out_q <= 8'h00;
                    busy_q     <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: begin
                    if (dir) begin
                        // PHY turned the bus around: drop the packet, no stp.
                        data_out_q <= 8'h00;
                        busy_q     <= 1'b0;
                        aborted_q  <= 1'b1;
                        state_q    <= S_IDLE;
                    end else if (nxt) begin
                        case (state_q)
                            S_TXCMD: begin
                                if (len_q != '0) begin
                                    data_out_q <= buf_q[7:0];
                                    state_q    <= S_DATA;
                                end else if (CRC_EN != 0) begin
                                    data_out_q <= ~crc_q[7:0];
                                    state_q    <= S_CRC_LO;
                                end else begin
                                    data_out_q <= 8'h00;
                                    stp_q      <= 1'b1;
                                    done_q     <= 1'b1;
                                    state_q    <= S_STOP;
                                end
                            end
                            S_DATA: begin
                                crc_q <= crc_d;
                                buf_q <= buf_d;
                                idx_q <= idx_d;
                                if (idx_d == len_q) begin
                                    if (CRC_EN != 0) begin
                                        data_out_q <= ~crc_d[7:0];
                                        state_q    <= S_CRC_LO;
                                    end else begin
                                        data_out_q <= 8'h00;
                                        stp_q      <= 1'b1;
                                        done_q     <= 1'b1;
                                        state_q    <= S_STOP;
                                    end
                                end else begin
                                    data_out_q <= buf_d[7:0];
                                end
                            end
                            S_CRC_LO: begin
                                data_out_q <= ~crc_q[15:8];
                                state_q    <= S_CRC_HI;
                            end
                            default: begin
                                data_out_q <= 8'h00;
                                stp_q      <= 1'b1;
                                done_q     <= 1'b1;
                                state_q    <= S_STOP;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign data_out = data_out_q;
    assign stp      = stp_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;

endmodule

// File: tb/tb_ulpi_tx_packetizer.sv
// Bench for ulpi_tx_packetizer: two instances (CRC on / CRC off, MAX_BYTES=8)
// share the PHY-side inputs. A negedge monitor pops the byte scoreboard
// whenever a byte is accepted (busy, no stp, nxt=1, dir=0).
module tb_ulpi_tx_packetizer;
    localparam int MB = 8;
    localparam int LW = $clog2(MB + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_a = 1'b0, start_b = 1'b0;
    logic [3:0]    pid = 4'h0;
    logic [LW-1:0] len_in = '0;
    logic [MB*8-1:0] data_in = '0;
    logic          nxt = 1'b0, dir = 1'b0;
    logic [7:0]    data_out_a, data_out_b;
    logic          stp_a, busy_a, done_a, aborted_a;
    logic          stp_b, busy_b, done_b, aborted_b;

    ulpi_tx_packetizer #(.MAX_BYTES(MB), .CRC_EN(1)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .pid(pid), .len_in(len_in),
        .data_in(data_in), .nxt(nxt), .dir(dir), .data_out(data_out_a),
        .stp(stp_a), .busy(busy_a), .done(done_a), .aborted(aborted_a));

    ulpi_tx_packetizer #(.MAX_BYTES(MB), .CRC_EN(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pid(pid), .len_in(len_in),
        .data_in(data_in), .nxt(nxt), .dir(dir), .data_out(data_out_b),
        .stp(stp_b), .busy(busy_b), .done(done_b), .aborted(aborted_b));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    logic [7:0] o_data[64];
    logic       o_stp[64], o_busy[64], o_done[64], o_abort[64];
    int stp_cnt, done_cnt, abort_cnt, busy_cnt;

    logic [3:0]      alt_pid;
    logic [LW-1:0]   alt_len;
    logic [MB*8-1:0] alt_data;

    // Software USB CRC16 model.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] != b[i]) r = (r >> 1) ^ 16'hA001;
            else              r = r >> 1;
        end
        return r;
    endfunction

    always @(negedge clk) begin : mon
        logic [7:0] e;
        if (!rst && busy_a && !stp_a && nxt && !dir) begin
            checks++;
            if (qa.size() == 0) begin
                errors++; $display("FAIL sb_a: byte %02h accepted, none expected", data_out_a);
            end else begin
                e = qa.pop_front();
                if (data_out_a !== e) begin errors++; $display("FAIL sb_a: got %02h want %02h", data_out_a, e); end
            end
        end
        if (!rst && busy_b && !stp_b && nxt && !dir) begin
            checks++;
            if (qb.size() == 0) begin
                errors++; $display("FAIL sb_b: byte %02h accepted, none expected", data_out_b);
            end else begin
                e = qb.pop_front();
                if (data_out_b !== e) begin errors++; $display("FAIL sb_b: got %02h want %02h", data_out_b, e); end
            end
        end
    end

    // Launch a packet on one instance and record its outputs for ncyc cycles.
    // toggle: nxt = 1,0,1,0... ; dir_c: cycle where dir rises (0 = never);
    // st1_c loads the alt inputs and pulses start, st2_c pulses start again.
    task automatic run(input bit sel_b, input int ncyc, input bit toggle,
                       input int dir_c, input int st1_c, input int st2_c);
        stp_cnt = 0; done_cnt = 0; abort_cnt = 0; busy_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            o_data[i] = 8'h00; o_stp[i] = 1'b0; o_busy[i] = 1'b0; o_done[i] = 1'b0; o_abort[i] = 1'b0;
        end
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            o_data[i]  = sel_b ? data_out_b : data_out_a;
            o_stp[i]   = sel_b ? stp_b : stp_a;
            o_busy[i]  = sel_b ? busy_b : busy_a;
            o_done[i]  = sel_b ? done_b : done_a;
            o_abort[i] = sel_b ? aborted_b : aborted_a;
            stp_cnt   += int'(o_stp[i]);
            done_cnt  += int'(o_done[i]);
            abort_cnt += int'(o_abort[i]);
            busy_cnt  += int'(o_busy[i]);
            @(posedge clk); #1;
            if (toggle) nxt = ((i + 1) % 2 == 1);
            if (i + 1 == dir_c) dir = 1'b1;
            if (i + 1 == st1_c) begin pid = alt_pid; len_in = alt_len; data_in = alt_data; end
            start_a = !sel_b && ((i + 1 == st1_c) || (i + 1 == st2_c));
            start_b =  sel_b && ((i + 1 == st1_c) || (i + 1 == st2_c));
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (data_out_a !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h want 00", data_out_a); end
        checks++; if (stp_a !== 1'b0) begin errors++; $display("FAIL rst_stp: got %b want 0", stp_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done_a); end
        checks++; if (aborted_a !== 1'b0) begin errors++; $display("FAIL rst_aborted: got %b want 0", aborted_a); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_data();
        logic [15:0] c;
        pid = 4'h1; len_in = LW'(8); nxt = 1'b1; dir = 1'b0;
        for (int k = 0; k < MB; k++) data_in[8*k +: 8] = 8'(8'h10 + k);
        qa.push_back(8'h41); qa.push_back(8'h10); qa.push_back(8'h11); qa.push_back(8'h12);
        run(1'b0, 4, 1'b0, 0, 0, 0);
        // now in cycle 5: byte index 3 on the bus
        nxt = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (data_out_a !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %02h want 00", data_out_a); end
        checks++; if (stp_a !== 1'b0) begin errors++; $display("FAIL mid_rst_stp: got %b want 0", stp_a); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy_a); end
        checks++; if (qa.size() != 0) begin errors++; $display("FAIL mid_rst_sb: %0d bytes left want 0", qa.size()); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        // next start works normally
        pid = 4'h2; len_in = LW'(1); data_in = '0; data_in[7:0] = 8'h5A; nxt = 1'b1;
        c = ~crc_step(16'hFFFF, 8'h5A);
        qa.push_back(8'h42); qa.push_back(8'h5A); qa.push_back(c[7:0]); qa.push_back(c[15:8]);
        run(1'b0, 6, 1'b0, 0, 0, 0);
        checks++; if (o_stp[5] !== 1'b1) begin errors++; $display("FAIL post_rst_stp: got %b want 1", o_stp[5]); end
        checks++; if (qa.size() != 0) begin errors++; $display("FAIL post_rst_sb: %0d bytes left want 0", qa.size()); end
    endtask

    task automatic test_zlp();
        pid = 4'h3; len_in = '0; nxt = 1'b1; dir = 1'b0;
        qa.push_back(8'h43); qa.push_back(8'h00); qa.push_back(8'h00);
        run(1'b0, 8, 1'b0, 0, 0, 0);
        checks++; if (busy_cnt != 4) begin errors++; $display("FAIL zlp_busy_cycles: got %0d want 4", busy_cnt); end
        checks++; if (o_stp[4] !== 1'b1) begin errors++; $display("FAIL zlp_stp: got %b want 1", o_stp[4]); end
        checks++; if (o_done[4] !== 1'b1) begin errors++; $display("FAIL zlp_done: got %b want 1", o_done[4]); end
        checks++; if (o_data[4] !== 8'h00) begin errors++; $display("FAIL zlp_stp_data: got %02h want 00", o_data[4]); end
        checks++; if (stp_cnt != 1) begin errors++; $display("FAIL zlp_stp_count: got %0d want 1", stp_cnt); end
        checks++; if (qa.size() != 0) begin errors++; $display("FAIL zlp_sb: %0d bytes left want 0", qa.size()); end
    endtask

    task automatic test_nxt_toggle();
        logic [15:0] c;
        logic [7:0]  e[6];
        pid = 4'hB; len_in = LW'(4); nxt = 1'b1; dir = 1'b0; data_in = '0;
        c = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            data_in[8*k +: 8] = 8'(k);
            c = crc_step(c, 8'(k));
            e[k] = 8'(k);
        end
        c = ~c;
        e[4] = c[7:0]; e[5] = c[15:8];
        qa.push_back(8'h4B);
        for (int k = 0; k < 6; k++) qa.push_back(e[k]);
        run(1'b0, 16, 1'b1, 0, 0, 0);
        checks++; if (o_data[1] !== 8'h4B) begin errors++; $display("FAIL tog_txcmd: got %02h want 4b", o_data[1]); end
        for (int k = 0; k < 6; k++) begin
            checks++; if (o_data[2+2*k] !== e[k]) begin errors++; $display("FAIL tog_byte%0d: got %02h want %02h", k, o_data[2+2*k], e[k]); end
            checks++; if (o_data[3+2*k] !== e[k]) begin errors++; $display("FAIL tog_hold%0d: got %02h want %02h", k, o_data[3+2*k], e[k]); end
        end
        checks++; if (o_stp[14] !== 1'b1) begin errors++; $display("FAIL tog_stp: got %b want 1", o_stp[14]); end
        checks++; if (stp_cnt != 1) begin errors++; $display("FAIL tog_stp_count: got %0d want 1", stp_cnt); end
        checks++; if (qa.size() != 0) begin errors++; $display("FAIL tog_sb: %0d bytes left want 0", qa.size()); end
    endtask

    task automatic test_abort();
        pid = 4'h5; len_in = LW'(8); nxt = 1'b1; dir = 1'b0;
        for (int k = 0; k < MB; k++) data_in[8*k +: 8] = 8'(8'h20 + k);
        qa.push_back(8'h45); qa.push_back(8'h20); qa.push_back(8'h21);
        run(1'b0, 6, 1'b0, 4, 0, 0);
        checks++; if (o_data[4] !== 8'h22) begin errors++; $display("FAIL abt_on_bus: got %02h want 22", o_data[4]); end
        checks++; if (o_abort[5] !== 1'b1) begin errors++; $display("FAIL abt_pulse: got %b want 1", o_abort[5]); end
        checks++; if (o_data[5] !== 8'h00) begin errors++; $display("FAIL abt_data: got %02h want 00", o_data[5]); end
        checks++; if (o_busy[5] !== 1'b0) begin errors++; $display("FAIL abt_busy: got %b want 0", o_busy[5]); end
        checks++; if (abort_cnt != 1) begin errors++; $display("FAIL abt_count: got %0d want 1", abort_cnt); end
        checks++; if (stp_cnt != 0) begin errors++; $display("FAIL abt_stp: got %0d want 0", stp_cnt); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL abt_done: got %0d want 0", done_cnt); end
        checks++; if (qa.size() != 0) begin errors++; $display("FAIL abt_sb: %0d bytes left want 0", qa.size()); end
        // dir still high: start must be ignored
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abt_start_dir: busy got %b want 0", busy_a); end
        @(posedge clk); #1;
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL abt_start_dir2: busy got %b want 0", busy_a); end
        dir = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_clamp();
        pid = 4'h6; len_in = LW'(MB + 5); nxt = 1'b1; dir = 1'b0;
        for (int k = 0; k < MB; k++) data_in[8*k +: 8] = 8'(8'h30 + k);
        qb.push_back(8'h46);
        for (int k = 0; k < MB; k++) qb.push_back(8'(8'h30 + k));
        run(1'b1, 12, 1'b0, 0, 0, 0);
        checks++; if (o_data[9] !== 8'h37) begin errors++; $display("FAIL clamp_last: got %02h want 37", o_data[9]); end
        checks++; if (o_stp[10] !== 1'b1) begin errors++; $display("FAIL clamp_stp: got %b want 1", o_stp[10]); end
        checks++; if (o_done[10] !== 1'b1) begin errors++; $display("FAIL clamp_done: got %b want 1", o_done[10]); end
        checks++; if (busy_cnt != 10) begin errors++; $display("FAIL clamp_busy: got %0d want 10", busy_cnt); end
        checks++; if (stp_cnt != 1) begin errors++; $display("FAIL clamp_stp_count: got %0d want 1", stp_cnt); end
        checks++; if (qb.size() != 0) begin errors++; $display("FAIL clamp_sb: %0d bytes left want 0", qb.size()); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] c;
        pid = 4'h7; len_in = LW'(2); nxt = 1'b1; dir = 1'b0;
        data_in = '0; data_in[7:0] = 8'h71; data_in[15:8] = 8'h72;
        alt_pid = 4'h8; alt_len = LW'(1);
        alt_data = {MB{8'hEE}}; alt_data[7:0] = 8'h99;
        c = ~crc_step(crc_step(16'hFFFF, 8'h71), 8'h72);
        qa.push_back(8'h47); qa.push_back(8'h71); qa.push_back(8'h72);
        qa.push_back(c[7:0]); qa.push_back(c[15:8]);
        c = ~crc_step(16'hFFFF, 8'h99);
        qa.push_back(8'h48); qa.push_back(8'h99);
        qa.push_back(c[7:0]); qa.push_back(c[15:8]);
        run(1'b0, 14, 1'b0, 0, 3, 7);
        checks++; if (o_stp[6] !== 1'b1) begin errors++; $display("FAIL b2b_stp1: got %b want 1", o_stp[6]); end
        checks++; if (o_busy[7] !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy got %b want 0", o_busy[7]); end
        checks++; if (o_data[8] !== 8'h48) begin errors++; $display("FAIL b2b_txcmd2: got %02h want 48", o_data[8]); end
        checks++; if (o_busy[8] !== 1'b1) begin errors++; $display("FAIL b2b_busy2: got %b want 1", o_busy[8]); end
        checks++; if (o_stp[12] !== 1'b1) begin errors++; $display("FAIL b2b_stp2: got %b want 1", o_stp[12]); end
        checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", done_cnt); end
        checks++; if (qa.size() != 0) begin errors++; $display("FAIL b2b_sb: %0d bytes left want 0", qa.size()); end
    endtask

    initial begin
        test_reset();
        test_reset_mid_data();
        test_zlp();
        test_nxt_toggle();
        test_abort();
        test_clamp();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
